// File: rtl/line_ram_reader_if.sv
// Pixel stream interface between the line RAM reader and its consumer.
// Signals:
//   m_data  : output pixel (RGB888 by default)
//   m_valid : beat valid, driven by the producer
//   m_ready : consumer accepts a beat when m_valid & m_ready
//   m_last  : marks the beat read from the final line address
// Modports: master (producer side), slave (consumer side).
interface line_ram_reader_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/line_ram_reader.sv
// Read-side controller for the single-port line RAM. A start pulse sweeps
// addresses 0..last_addr, hides the RAM's one-cycle read latency behind a
// 2-entry FIFO and presents the line as a valid/ready pixel stream.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse beginning a line read (ignored while busy)
//   last_addr    : inclusive final address, sampled with start
//   busy         : high while a line read is in progress
//   done         : one-cycle pulse after the final beat is accepted
//   ram_addr     : registered RAM read address
//   ram_rd_data  : RAM read data, valid the cycle after ram_addr is sampled
//   m            : pixel stream (master modport)
module line_ram_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    line_ram_reader_if.master     m
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] last_r;
    logic                  inflight_r;
    logic                  inflight_last_r;
    logic [DATA_WIDTH-1:0] fifo_data_r [0:1];
    logic                  fifo_last_r [0:1];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;

    logic                  pop_s;
    logic                  push_s;
    logic                  issue_ok_s;
    logic                  issue_s;
    logic                  at_last_s;
    logic                  accept_start_s;

    // Stream outputs come straight from the FIFO head registers.
    assign m.m_valid = (count_r != 2'd0);
    assign m.m_data  = fifo_data_r[rd_ptr_r];
    assign m.m_last  = fifo_last_r[rd_ptr_r] & (count_r != 2'd0);

    // Handshake, issue decision and next-state logic.
    always_comb begin
        pop_s          = (count_r != 2'd0) & m.m_ready;
        push_s         = inflight_r;
        at_last_s      = (ram_addr == last_r);
        // Entries held plus the one in flight, after this cycle's pop,
        // must leave room for the data of a new issue.
        issue_ok_s     = (({1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s}) < 3'd2);
        issue_s        = (state_r == ISSUE) & issue_ok_s;
        // A start coinciding with done is dropped.
        accept_start_s = start & ~done;
        state_s        = state_r;
        case (state_r)
            IDLE: begin
                if (accept_start_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (issue_s && at_last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                // Leave as soon as the final beat is being accepted so done
                // lands on the cycle right after it.
                if (!inflight_r && ((count_r - {1'b0, pop_s}) == 2'd0)) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, address generator, in-flight tracking and FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            ram_addr        <= {ADDR_WIDTH{1'b0}};
            last_r          <= {ADDR_WIDTH{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            fifo_data_r[0]  <= {DATA_WIDTH{1'b0}};
            fifo_data_r[1]  <= {DATA_WIDTH{1'b0}};
            fifo_last_r[0]  <= 1'b0;
            fifo_last_r[1]  <= 1'b0;
            wr_ptr_r        <= 1'b0;
            rd_ptr_r        <= 1'b0;
            count_r         <= 2'd0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            done    <= (state_r == DRAIN) && (state_s == IDLE);

            if ((state_r == IDLE) && accept_start_s) begin
                ram_addr <= {ADDR_WIDTH{1'b0}};
                last_r   <= last_addr;
            end else if (issue_s && !at_last_s) begin
                // The final address is held, so a full-size line never wraps.
                ram_addr <= ram_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                ram_addr <= ram_addr;
            end

            inflight_r      <= issue_s;
            inflight_last_r <= issue_s & at_last_s;

            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= ram_rd_data;
                fifo_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

endmodule

// File: tb/tb_line_ram_reader.sv
// Directed testbench for line_ram_reader with a line-level reference model:
// the model knows which pixel index must come next, when busy/done must
// change and how many reads may be outstanding.
module tb_line_ram_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] last_addr;
    logic        busy;
    logic        done;
    logic [10:0] ram_addr;
    logic [23:0] ram_rd_data;
    logic [23:0] mem [0:2047];

    line_ram_reader_if #(.DATA_WIDTH(24)) sif ();

    line_ram_reader #(.ADDR_WIDTH(11), .DATA_WIDTH(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .last_addr   (last_addr),
        .busy        (busy),
        .done        (done),
        .ram_addr    (ram_addr),
        .ram_rd_data (ram_rd_data),
        .m           (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM, no output register.
    always @(posedge clk) ram_rd_data <= mem[ram_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    bit        armed = 1'b0;
    bit        exp_busy = 1'b0;
    bit        exp_done = 1'b0;
    int        line_l = 0;
    int        idx = 0;
    int        lines_done = 0;
    int        start_cyc = 0;
    int        first_cyc = 0;
    int        last_cyc = 0;
    int        beats = 0;
    int        peak = 0;
    bit        prev_hold = 1'b0;
    logic [23:0] prev_data;
    logic        prev_last;

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit nb;
        bit nd;
        if (armed) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (!exp_busy) chk("valid_idle", {31'd0, sif.m_valid}, 32'd0);
            if (prev_hold) begin
                chk("hold_valid", {31'd0, sif.m_valid}, 32'd1);
                chk("hold_data", {8'd0, sif.m_data}, {8'd0, prev_data});
                chk("hold_last", {31'd0, sif.m_last}, {31'd0, prev_last});
            end
            if (exp_busy) begin
                chk("addr_max", {31'd0, (int'(ram_addr) <= line_l)}, 32'd1);
                chk("outstanding", {31'd0, (int'(ram_addr) <= idx + 2)}, 32'd1);
            end
        end
        nb = exp_busy;
        nd = 1'b0;
        if (rst) begin
            nb        = 1'b0;
            idx       = 0;
            prev_hold = 1'b0;
            armed     = 1'b1;
        end else begin
            if (armed && exp_busy && sif.m_valid && sif.m_ready) begin
                chk("beat_data", {8'd0, sif.m_data}, 32'h0010_0000 + idx);
                chk("beat_last", {31'd0, sif.m_last}, {31'd0, (idx == line_l)});
                if (idx == 0) first_cyc = cyc;
                if (idx == line_l) begin
                    nb         = 1'b0;
                    nd         = 1'b1;
                    last_cyc   = cyc;
                    beats      = idx + 1;
                    lines_done = lines_done + 1;
                end
                idx = idx + 1;
            end
            if (exp_busy && int'(ram_addr) > peak) peak = int'(ram_addr);
            if (armed && !exp_busy && !exp_done && start) begin
                nb        = 1'b1;
                line_l    = int'(last_addr);
                idx       = 0;
                start_cyc = cyc;
                peak      = 0;
                beats     = 0;
            end
            prev_hold = armed && exp_busy && sif.m_valid && !sif.m_ready;
            prev_data = sif.m_data;
            prev_last = sif.m_last;
        end
        exp_busy = nb;
        exp_done = nd;
    end

    // mode 0: ready high; mode 1: stall cycles 4-9 then alternate;
    // mode 2: ready high with a stray start at cycle 5.
    task automatic run_line(input int l, input int mode, input bit start_at_done, input bit abort);
        int base;
        bit fin;
        base = lines_done;
        fin  = 1'b0;
        @(posedge clk); #1;
        start         = 1'b1;
        last_addr     = 11'(l);
        sif.m_ready   = 1'b1;
        for (int k = 1; k < 3 * l + 60; k++) begin
            @(posedge clk); #1;
            start = (mode == 2) && (k == 5);
            if (mode == 1) begin
                if (k >= 4 && k <= 9) sif.m_ready = 1'b0;
                else if (k >= 10)     sif.m_ready = (k % 2 == 0);
                else                  sif.m_ready = 1'b1;
                if (k == 9) begin
                    chk("stall_addr", {21'd0, ram_addr}, 32'd3);
                    chk("stall_data", {8'd0, sif.m_data}, 32'h0010_0001);
                end
            end
            if (lines_done != base) begin
                fin = 1'b1;
                if (start_at_done) start = 1'b1;
                break;
            end
            if (abort && idx >= 3) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst   = 1'b0;
                start = 1'b0;
                fin   = 1'b1;
                break;
            end
        end
        if (!fin) chk("line_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 24'h10_0000 + 24'(i);
        rst         = 1'b1;
        start       = 1'b0;
        last_addr   = 11'd7;
        sif.m_ready = 1'b1;

        // 1: reset with start pulsed inside it
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, sif.m_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {21'd0, ram_addr}, 32'd0);

        // 2: basic line
        run_line(7, 0, 1'b0, 1'b0);
        chk("t2_latency", first_cyc - start_cyc, 32'd3);
        chk("t2_beats", beats, 32'd8);
        chk("t2_span", last_cyc - first_cyc, 32'd7);
        chk("t2_peak", peak, 32'd7);

        // 3: backpressure
        run_line(7, 1, 1'b0, 1'b0);
        chk("t3_beats", beats, 32'd8);
        chk("t3_peak", peak, 32'd7);

        // 4: single-pixel line
        run_line(0, 0, 1'b0, 1'b0);
        chk("t4_beats", beats, 32'd1);
        chk("t4_peak", peak, 32'd0);
        chk("t4_latency", first_cyc - start_cyc, 32'd3);

        // 5: full line, start held through done, then repeat
        run_line(2047, 0, 1'b1, 1'b0);
        chk("t5a_beats", beats, 32'd2048);
        chk("t5a_span", last_cyc - first_cyc, 32'd2047);
        chk("t5a_peak", peak, 32'd2047);
        run_line(2047, 0, 1'b0, 1'b0);
        chk("t5b_restart", first_cyc - start_cyc, 32'd3);
        chk("t5b_beats", beats, 32'd2048);
        chk("t5b_span", last_cyc - first_cyc, 32'd2047);
        chk("t5b_peak", peak, 32'd2047);

        // 6: stray start, then reset mid-line, then a clean line
        run_line(7, 2, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_valid", {31'd0, sif.m_valid}, 32'd0);
        chk("t6_last", {31'd0, sif.m_last}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_addr", {21'd0, ram_addr}, 32'd0);
        chk("t6_data", {8'd0, sif.m_data}, 32'd0);
        repeat (3) @(posedge clk);
        run_line(7, 0, 1'b0, 1'b0);
        chk("t6_beats", beats, 32'd8);
        chk("t6_latency", first_cyc - start_cyc, 32'd3);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
